// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and types for the registered 8-bit adder.
//   ADDER_WIDTH - operand width in bits
//   result_t    - full-width result {carry-out, sum}, one bit wider than the operands
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH:0] result_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder, the unit cell of the ripple chain.
// Ports:
//   x, y - operand bits
//   ci   - carry in
//   s    - sum bit
//   co   - carry out
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/adder8.sv
// adder8: registered 8-bit ripple-carry adder, {cout, sum} = a + b + cin.
// Operands sampled on a rising edge appear on the outputs right after that edge.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - a/b/cin carry an operation this cycle
//   a, b      - unsigned 8-bit operands
//   cin       - carry in
//   sum       - registered result bits [7:0]
//   cout      - registered carry out (result bit 8)
//   out_valid - sum/cout were written by the previous edge
module adder8
  import adder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   cout,
  output logic                   out_valid
);

  logic [ADDER_WIDTH:0]   c;
  logic [ADDER_WIDTH-1:0] s_p0;
  result_t                res_p0;
  result_t                res_p1;
  logic                   vld_p1;

  // Stage p0: combinational ripple chain from the operand ports.
  assign c[0] = cin;

  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (s_p0[i]),
      .co (c[i+1])
    );
  end

  assign res_p0 = {c[ADDER_WIDTH], s_p0};

  // Stage p1: result register. The result only updates on an accepted
  // operation so it holds through idle cycles; the valid flag follows
  // in_valid every cycle. Reset clears the result as well as the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1 <= res_p0;
      end
    end
  end

  assign sum       = res_p1[ADDER_WIDTH-1:0];
  assign cout      = res_p1[ADDER_WIDTH];
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_adder8.sv
// tb_adder8: directed and swept checks of the registered 8-bit adder.
module tb_adder8;
  import adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  // Drive one cycle of inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [7:0] ia,
                      input logic [7:0] ib, input logic ic);
    rst      = r;
    in_valid = v;
    a        = ia;
    b        = ib;
    cin      = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    n_vec++;
    assert ({cout, sum, out_valid} === {ec, es, ev})
    else begin
      n_err++;
      $error("FAIL %s: observed sum=%h cout=%b vld=%b, expected sum=%h cout=%b vld=%b",
             tag, sum, cout, out_valid, es, ec, ev);
    end
  endtask

  initial begin
    logic [7:0] bset [6];
    result_t    r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h7F;
    bset[3] = 8'h80; bset[4] = 8'hFE; bset[5] = 8'hFF;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous valid operation.
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("reset_with_valid", 8'h00, 1'b0, 1'b0);

    // First operation accepted on the edge right after reset release.
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    chk("basic_add", 8'h02, 1'b0, 1'b1);

    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
    chk("cin_ripple_wrap", 8'h00, 1'b1, 1'b1);

    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("max_inputs", 8'hFF, 1'b1, 1'b1);

    step(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
    chk("wrap_ff_plus_1", 8'h00, 1'b1, 1'b1);

    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("zero", 8'h00, 1'b0, 1'b1);

    // Hold: idle cycles keep the last result while the operands change.
    step(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
    chk("hold_load", 8'h10, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'hAA, 8'h55, 1'b1);
    chk("hold_idle1", 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    chk("hold_idle2", 8'h10, 1'b0, 1'b0);

    // Back-to-back operations, no bubbles.
    step(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    chk("b2b_0", 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h55, 8'hAA, 1'b0);
    chk("b2b_1", 8'hFF, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h55, 8'hAA, 1'b1);
    chk("b2b_2", 8'h00, 1'b1, 1'b1);

    step(1'b0, 1'b1, 8'h3C, 8'h5A, 1'b1);
    chk("mixed_bits", 8'h97, 1'b0, 1'b1);

    // Reset in mid-stream clears a non-zero result.
    step(1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
    chk("reset_midstream", 8'h00, 1'b0, 1'b0);

    // All a values against boundary b values, both carry-ins.
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 6; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r = result_t'(ia) + result_t'(bset[ib]) + result_t'(ic);
          step(1'b0, 1'b1, 8'(ia), bset[ib], 1'(ic));
          chk("sweep", r[7:0], r[8], 1'b1);
        end
      end
    end

    // Random vectors with occasional idle cycles.
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      r  = result_t'(ra) + result_t'(rb) + result_t'(rc);
      step(1'b0, 1'b1, ra, rb, rc);
      chk("random", r[7:0], r[8], 1'b1);
      if ((k % 97) == 0) begin
        step(1'b0, 1'b0, ~ra, ~rb, ~rc);
        chk("random_hold", r[7:0], r[8], 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
